// File: rtl/down_count_pkg.sv
// Shared types and constants for the 7-bit down counter, its period monitor and benches.
package down_count_pkg;

    localparam int unsigned COUNT_W = 7;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 7'd127;

    // Measurement FSM states of the period monitor.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/down_count_wrap_detect.sv
// Samples the counter Q each enabled cycle; flags wraps (0 -> max) and illegal steps.
module down_count_wrap_detect
    import down_count_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    output logic             prev_valid,
    output logic             wrap_c,
    output logic             hold_c,
    output logic             period_tick,
    output logic             seq_err
);

    localparam logic [WIDTH-1:0] WRAP_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] prev;
    logic             step_ok_c;

    // A sample is legal if it holds or steps down by one (modulo wraps naturally).
    assign step_ok_c = (count_in == prev) || (count_in == (prev - WIDTH'(1)));
    assign hold_c    = enable && prev_valid && (count_in == prev);
    assign wrap_c    = enable && prev_valid && (prev == '0) && (count_in == WRAP_VAL);

    // Sample register, registered wrap tick and sticky step-error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev        <= '0;
            prev_valid  <= 1'b0;
            period_tick <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            period_tick <= wrap_c;
            if (enable) begin
                prev       <= count_in;
                prev_valid <= 1'b1;
                if (prev_valid && !step_ok_c) begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/down_count_period_monitor.sv
// Counts down-counter periods (wraps) against a programmed target with start/busy/done.
// Optional stall watchdog enabled by defining DOWN_COUNT_STALL_DETECT_EN.
module down_count_period_monitor
    import down_count_pkg::*;
#(
    parameter int unsigned WIDTH       = COUNT_W,
    parameter int unsigned PCNT_W      = 4,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              start,
    input  logic [PCNT_W-1:0] target_periods,
    output logic              busy,
    output logic              done,
    output logic              period_tick,
    output logic [PCNT_W-1:0] periods_seen,
    output logic              seq_err,
    output logic              stall_err
);

    localparam logic [PCNT_W-1:0] PCNT_MAX = {PCNT_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [PCNT_W-1:0] target_q;
    logic [PCNT_W-1:0] target_nxt;
    logic [PCNT_W-1:0] periods_nxt;
    logic              prev_valid;
    logic              wrap_c;
    logic              hold_c;

    down_count_wrap_detect #(
        .WIDTH (WIDTH)
    ) u_wrap_detect (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .count_in    (count_in),
        .prev_valid  (prev_valid),
        .wrap_c      (wrap_c),
        .hold_c      (hold_c),
        .period_tick (period_tick),
        .seq_err     (seq_err)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, target latch and period count; wraps only count while COUNTING.
    always_comb begin
        state_nxt   = state;
        target_nxt  = target_q;
        periods_nxt = periods_seen;
        case (state)
            IDLE: begin
                if (start) begin
                    target_nxt  = target_periods;
                    periods_nxt = '0;
                    state_nxt   = (target_periods == '0) ? DONE : ARMED;
                end
            end
            ARMED: begin
                if (enable && prev_valid) begin
                    state_nxt = COUNTING;
                end
            end
            COUNTING: begin
                if (wrap_c) begin
                    if (periods_seen != PCNT_MAX) begin
                        periods_nxt = periods_seen + PCNT_W'(1);
                    end
                    if (periods_nxt == target_q) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered datapath and status outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q     <= '0;
            periods_seen <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            target_q     <= target_nxt;
            periods_seen <= periods_nxt;
            busy         <= (state_nxt == ARMED) || (state_nxt == COUNTING);
            done         <= (state_nxt == DONE);
        end
    end

`ifdef DOWN_COUNT_STALL_DETECT_EN
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] stall_cnt;

    // Watchdog: consecutive enabled samples with an unchanged count set a sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (hold_c) begin
            if (stall_cnt != STALL_W'(STALL_LIMIT)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (stall_cnt >= STALL_W'(STALL_LIMIT - 1)) begin
                stall_err <= 1'b1;
            end
        end else if (enable) begin
            stall_cnt <= '0;
        end
    end
`else
    logic unused_stall;

    // Watchdog compiled out; the flag is held low.
    assign unused_stall = hold_c | (STALL_LIMIT == 0);
    assign stall_err    = 1'b0;
`endif

endmodule

// File: tb/tb_down_count_period_monitor.sv
// Self-checking bench for down_count_period_monitor against a behavioural model.
module tb_down_count_period_monitor;
    import down_count_pkg::*;

    localparam int MAXV  = int'(COUNT_MAX);
    localparam int MODV  = MAXV + 1;
    localparam int PMAX  = 15;
    localparam int SLIM  = 16;
    localparam int P_IDLE = 0, P_ARMED = 1, P_COUNT = 2, P_DONE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] count_in = 7'd127;
    logic       start = 1'b0;
    logic [3:0] target_periods = 4'd0;
    logic       busy, done, period_tick, seq_err, stall_err;
    logic [3:0] periods_seen;
    logic [8:0] obs;

    int n_checks = 0;
    int n_fail = 0;

    // model state
    int m_prev = -1;
    int m_phase = P_IDLE;
    int m_tgt = 0;
    int m_ps = 0;
    int m_scnt = 0;
    bit m_busy = 0, m_done = 0, m_tick = 0, m_seq = 0, m_stall = 0;

    down_count_period_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .count_in       (count_in),
        .start          (start),
        .target_periods (target_periods),
        .busy           (busy),
        .done           (done),
        .period_tick    (period_tick),
        .periods_seen   (periods_seen),
        .seq_err        (seq_err),
        .stall_err      (stall_err)
    );

    always #5 clk = ~clk;

    assign obs = {busy, done, period_tick, periods_seen, seq_err, stall_err};

    // Behavioural reference: measurement rules applied to plain integers per clock.
    always @(posedge clk or negedge reset) begin
        int  ci;
        bit  wrap;
        bit  had_prev;
        if (!reset) begin
            m_prev = -1; m_phase = P_IDLE; m_tgt = 0; m_ps = 0; m_scnt = 0;
            m_busy = 0; m_done = 0; m_tick = 0; m_seq = 0; m_stall = 0;
        end else begin
            ci       = int'(count_in);
            had_prev = (m_prev >= 0);
            wrap     = enable && had_prev && m_prev == 0 && ci == MAXV;
            m_tick   = wrap;
            if (enable && had_prev && ci != m_prev && ci != (m_prev + MODV - 1) % MODV)
                m_seq = 1;
`ifdef DOWN_COUNT_STALL_DETECT_EN
            if (enable) begin
                if (had_prev && ci == m_prev) begin
                    m_scnt++;
                    if (m_scnt >= SLIM) m_stall = 1;
                end else begin
                    m_scnt = 0;
                end
            end
`endif
            case (m_phase)
                P_IDLE: if (start) begin
                    m_tgt = int'(target_periods);
                    m_ps = 0;
                    m_phase = (m_tgt == 0) ? P_DONE : P_ARMED;
                end
                P_ARMED: if (enable && had_prev) m_phase = P_COUNT;
                P_COUNT: if (wrap) begin
                    if (m_ps < PMAX) m_ps++;
                    if (m_ps == m_tgt) m_phase = P_DONE;
                end
                default: m_phase = P_IDLE;
            endcase
            m_busy = (m_phase == P_ARMED) || (m_phase == P_COUNT);
            m_done = (m_phase == P_DONE);
            if (enable) m_prev = ci;
        end
    end

    function automatic logic [8:0] exp_vec();
        return {m_busy, m_done, m_tick, 4'(m_ps), m_seq, m_stall};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #3;
        n_checks++;
        if (obs !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", obs, 9'd0);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_checks++;
            if (obs !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_held cyc %0d: got %b want %b", k, obs, 9'd0);
            end
        end
    endtask

    task automatic test_free_run();
        int first_tick = -1;
        reset = 1'b1;
        enable = 1'b1;
        count_in = 7'd127;
        for (int k = 1; k <= 140; k++) begin
            cyc();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL free_run cyc %0d: got %b want %b", k, obs, exp_vec());
            end
            if (period_tick === 1'b1 && first_tick < 0) first_tick = k;
            count_in = count_in - 7'd1;
        end
        n_checks++;
        if (first_tick != 129) begin
            n_fail++;
            $display("FAIL first_tick: got %0d want 129", first_tick);
        end
    endtask

    task automatic test_measure_three();
        int  dones = 0;
        bit  got = 0;
        start = 1'b1;
        target_periods = 4'd3;
        cyc();
        start = 1'b0;
        count_in = count_in - 7'd1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL measure_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 600 && !got; i++) begin
            cyc();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL measure cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (done === 1'b1) begin
                dones++;
                got = 1;
            end
            count_in = count_in - 7'd1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL measure_timeout: got no done want done within 600 cycles");
        end
        cyc();
        if (done === 1'b1) dones++;
        count_in = count_in - 7'd1;
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL measure_done_count: got %0d want 1", dones);
        end
        n_checks++;
        if (periods_seen !== 4'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL measure_final: got ps=%0d busy=%b want ps=3 busy=0", periods_seen, busy);
        end
    endtask

    task automatic test_target_zero();
        start = 1'b1;
        target_periods = 4'd0;
        cyc();
        start = 1'b0;
        count_in = count_in - 7'd1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || periods_seen !== 4'd0) begin
            n_fail++;
            $display("FAIL target_zero_done: got done=%b busy=%b ps=%0d want 1 0 0", done, busy, periods_seen);
        end
        cyc();
        count_in = count_in - 7'd1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL target_zero_after: got done=%b busy=%b want 0 0", done, busy);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL target_zero_model: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_seq_err();
        logic [6:0] seq [6] = '{7'd50, 7'd50, 7'd47, 7'd46, 7'd45, 7'd45};
        logic [0:0] want [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        pulse_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            count_in = seq[i];
            cyc();
            n_checks++;
            if (seq_err !== want[i][0] || obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL seq_err step %0d: got err=%b obs=%b want err=%b obs=%b",
                         i, seq_err, obs, want[i][0], exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        pulse_reset();
        enable = 1'b1;
        count_in = 7'd10;
        start = 1'b1;
        target_periods = 4'd5;
        cyc();
        start = 1'b0;
        count_in = count_in - 7'd1;
        for (int i = 0; i < 600 && !got; i++) begin
            cyc();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid run cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (periods_seen === 4'd2) got = 1;
            count_in = count_in - 7'd1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL reset_mid_timeout: got ps=%0d want 2 within 600 cycles", periods_seen);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got %b want %b", obs, 9'd0);
        end
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            count_in = count_in - 7'd1;
            n_checks++;
            if (done !== 1'b0 || obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_stall();
        logic want;
`ifdef DOWN_COUNT_STALL_DETECT_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        pulse_reset();
        enable = 1'b1;
        count_in = 7'd20;
        for (int i = 0; i < 18; i++) begin
            cyc();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (stall_err !== want) begin
            n_fail++;
            $display("FAIL stall_flag: got %b want %b", stall_err, want);
        end
    endtask

    task automatic test_random();
        pulse_reset();
        count_in = 7'($urandom_range(0, 127));
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) pulse_reset();
            enable = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 19) == 0);
            target_periods = 4'($urandom_range(0, 4));
            cyc();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (i > 2000 && $urandom_range(0, 499) == 0)
                count_in = 7'($urandom_range(0, 127));
            else if (enable && $urandom_range(0, 9) != 0)
                count_in = count_in - 7'd1;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_measure_three();
        test_target_zero();
        test_seq_err();
        test_reset_mid();
        test_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
